serial_adder: RTL and testbench

- Bit-serial ripple adder built around one full-adder cell (one sum bit, one carry bit per cycle) and a registered carry loop.
- Captures two WIDTH-bit operands and a carry-in on a start handshake, then adds LSB-first, one bit per clock.
- Presents a registered WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits between the operand source and any consumer of multi-bit sums. It trades WIDTH cycles of latency for a single adder cell.

---
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built around a single full-adder cell with a
// registered carry loop. Operands are captured on an accepted start and summed
// LSB-first, one bit per clock; the WIDTH-bit sum and the final carry-out are
// published together with a one-cycle done pulse.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous, active-high reset (abandons any addition in flight)
//   start - request; accepted in IDLE or DONE (never while busy)
//   a, b  - WIDTH-bit operands, captured on the accepting edge
//   ci    - carry-in, captured on the accepting edge into the carry register
//   busy  - high while bits are being processed (SHIFT)
//   done  - one-cycle pulse; sum/co were updated on the edge that raised it
//   sum   - registered result, held until the next completion
//   co    - registered final carry-out, held until the next completion
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  // A 1-bit counter is kept for WIDTH=1 so the counter never collapses to zero width.
  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       fa;
  logic             accept;
  logic             last_bit;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == SHIFT) && (cnt == LAST_BIT);

  // Full-adder cell, computed at 2 bits so the carry survives until the split.
  assign fa = {1'b0, a_sh[0]} + {1'b0, b_sh[0]} + {1'b0, carry};

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    res_nxt            = res_sh >> 1;
    res_nxt[WIDTH-1]   = fa[0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? SHIFT : IDLE;
      SHIFT:   state_nxt = last_bit ? DONE : SHIFT;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Datapath: operand shifters, carry loop, result assembly and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      co     <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= ci;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa[1];
      res_sh <= res_nxt;
      cnt    <= cnt + 1'b1;
      // sum/co only ever change here, so consumers never see partial results.
      if (last_bit) begin
        sum <= res_nxt;
        co  <= fa[1];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00;
  logic [7:0] b8 = 8'h00;
  logic       ci8 = 1'b0;
  logic       busy8, done8, co8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       ci1 = 1'b0;
  logic       busy1, done1, co1;
  logic       sum1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [8:0] val;
    int         acc;
  } exp8_t;

  typedef struct {
    logic [1:0] val;
    int         acc;
  } exp1_t;

  exp8_t q8[$];
  exp1_t q1[$];
  logic [8:0] last8 = 9'd0;
  logic [1:0] last1 = 2'd0;
  logic       prev_done8 = 1'b0;
  logic       prev_done1 = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted start promises the plain sum a+b+ci, WIDTH edges later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && start8 && !busy8)
      q8.push_back('{9'(a8) + 9'(b8) + 9'(ci8), cyc + 1});
    if (!rst && start1 && !busy1)
      q1.push_back('{2'(a1) + 2'(b1) + 2'(ci1), cyc + 1});
  end

  always @(posedge rst) begin
    q8.delete();
    q1.delete();
    last8 = 9'd0;
    last1 = 2'd0;
  end

  // Monitor: compare whenever done is presented; otherwise outputs must hold.
  always @(negedge clk) begin
    exp8_t e8;
    exp1_t e1;
    if (!rst) begin
      if (done8) begin
        chk("done_pulse8", 32'(prev_done8), 32'd0);
        if (q8.size() == 0) begin
          chk("spurious_done8", 32'(done8), 32'd0);
        end else begin
          e8 = q8.pop_front();
          chk("result8", 32'({co8, sum8}), 32'(e8.val));
          chk("latency8", 32'(cyc - e8.acc), 32'd8);
          last8 = {co8, sum8};
        end
      end else begin
        chk("hold8", 32'({co8, sum8}), 32'(last8));
      end
      if (done1) begin
        chk("done_pulse1", 32'(prev_done1), 32'd0);
        if (q1.size() == 0) begin
          chk("spurious_done1", 32'(done1), 32'd0);
        end else begin
          e1 = q1.pop_front();
          chk("result1", 32'({co1, sum1}), 32'(e1.val));
          chk("latency1", 32'(cyc - e1.acc), 32'd1);
          last1 = {co1, sum1};
        end
      end else begin
        chk("hold1", 32'({co1, sum1}), 32'(last1));
      end
    end
    prev_done8 <= rst ? 1'b0 : done8;
    prev_done1 <= rst ? 1'b0 : done1;
  end

  // Waits for the DUT to be able to accept, then presents the operands for one cycle.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int n = 0;
    @(negedge clk);
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy8) chk("accept_timeout8", 32'(busy8), 32'd0);
    a8 = x; b8 = y; ci8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
  endtask

  task automatic op1(input logic x, input logic y, input logic c);
    int n = 0;
    @(negedge clk);
    while (busy1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy1) chk("accept_timeout1", 32'(busy1), 32'd0);
    a1 = x; b1 = y; ci1 = c; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done8) chk("done_timeout8", 32'(done8), 32'd1);
  endtask

  initial begin
    int n;
    int t1;
    int t2;
    int ndone;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'({co8, sum8}), 32'd0);
    chk("rst_w1", 32'({busy1, done1, co1, sum1}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: basic add, busy length and done pulse
    op8(8'h5A, 8'h3C, 1'b0);
    n = 0;
    while (busy8 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", 32'(n), 32'd8);
    chk("t1_done", 32'(done8), 32'd1);
    chk("t1_sum", 32'(sum8), 32'h96);
    chk("t1_co", 32'(co8), 32'd0);
    @(negedge clk);
    chk("t1_done_drop", 32'(done8), 32'd0);

    // Test 2: overflow corners
    op8(8'hFF, 8'h01, 1'b0); wait_done8();
    chk("t2a", 32'({co8, sum8}), 32'h100);
    op8(8'hFF, 8'hFF, 1'b1); wait_done8();
    chk("t2b", 32'({co8, sum8}), 32'h1FF);
    op8(8'h00, 8'h00, 1'b1); wait_done8();
    chk("t2c", 32'({co8, sum8}), 32'h001);

    // Test 3: start held, operands changing every cycle
    @(negedge clk);
    n = 0;
    while (busy8 && n < 50) begin @(negedge clk); n++; end
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; start8 = 1'b1;
    ndone = 0; t1 = 0; t2 = 0;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      @(negedge clk);
      if (done8) begin
        if (ndone == 0) begin
          chk("t3_first", 32'({co8, sum8}), 32'h046);
          t1 = cyc;
        end else begin
          t2 = cyc;
        end
        ndone++;
      end
      if (ndone < 2) begin
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      end
    end
    start8 = 1'b0;
    chk("t3_two_done", 32'(ndone), 32'd2);
    chk("t3_spacing", 32'(t2 - t1), 32'd9);

    // Test 4: reset mid-SHIFT
    op8(8'hAA, 8'h55, 1'b0);
    repeat (4) @(negedge clk);
    chk("t4_busy_before", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    chk("t4_rst_busy", 32'(busy8), 32'd0);
    chk("t4_rst_done", 32'(done8), 32'd0);
    chk("t4_rst_sum_co", 32'({co8, sum8}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    op8(8'h01, 8'h01, 1'b0); wait_done8();
    chk("t4_after", 32'({co8, sum8}), 32'h002);

    // Test 5: WIDTH=1, all combinations
    for (int i = 0; i < 8; i++) begin
      op1(i[0], i[1], i[2]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Test 6: random regression with random gaps
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    n = 0;
    while ((q8.size() + q1.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q8.size() + q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
